mem_port_arbiter: RTL and testbench

//  Shares one single-ported synchronous instruction/data memory between the fetch stage
//  (instruction reads) and the memory stage (loads/stores) of the 5-stage pipeline.
//  Per-requester req/gnt/rvalid handshakes; data-side priority with fetch anti-starvation.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and the data stage.
// Data side has priority; a fetch starved for STARVE_MAX data grants is forced through.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        flush,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned SC_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);
  localparam logic [SC_W-1:0]  SC_END  = SC_W'(STARVE_MAX);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;

  logic [1:0]       state, state_n;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
  logic [SC_W-1:0]  starve_cnt, starve_cnt_n;
  logic             kill, kill_n;
  logic             store_q, store_n;

  logic resp, slot, force_if, win_dm, win_if;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

  // A grant slot is any idle cycle or the response cycle of the current access.
  assign resp     = (state != ST_IDLE) && (lat_cnt == LAT_END);
  assign slot     = reset && ((state == ST_IDLE) || resp);
  assign force_if = if_req && (starve_cnt == SC_END);
  assign win_dm   = slot && dm_req && !force_if;
  assign win_if   = slot && if_req && !win_dm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      kill       <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      state      <= state_n;
      lat_cnt    <= lat_cnt_n;
      starve_cnt <= starve_cnt_n;
      kill       <= kill_n;
      store_q    <= store_n;
    end
  end

  always_comb begin
    state_n      = state;
    lat_cnt_n    = lat_cnt;
    starve_cnt_n = starve_cnt;
    kill_n       = kill;
    store_n      = store_q;
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    dm_rvalid    = 1'b0;
    dm_rdata     = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = 4'h0;

    if ((state != ST_IDLE) && !resp)
      lat_cnt_n = lat_cnt + LAT_W'(1);

    if (slot) begin
      if (win_dm) begin
        state_n   = ST_BUSY_DM;
        lat_cnt_n = LAT_W'(1);
        store_n   = dm_we;
        dm_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = {dm_addr[31:2], 2'b00};
        mem_wdata = dm_we ? dm_wdata : 32'h0;
        mem_be    = dm_we ? dm_be : 4'hF;
      end else if (win_if) begin
        state_n   = ST_BUSY_IF;
        lat_cnt_n = LAT_W'(1);
        store_n   = 1'b0;
        if_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = {if_addr[31:2], 2'b00};
        mem_be    = 4'hF;
      end else begin
        state_n   = ST_IDLE;
        lat_cnt_n = '0;
      end
    end

    // A redirect kills the fetch being granted or any fetch still in flight.
    if (win_if)
      kill_n = flush;
    else if (resp)
      kill_n = 1'b0;
    else if ((state == ST_BUSY_IF) && flush)
      kill_n = 1'b1;

    if (!if_req || win_if)
      starve_cnt_n = '0;
    else if (win_dm && (starve_cnt != SC_END))
      starve_cnt_n = starve_cnt + SC_W'(1);

    if (resp && (state == ST_BUSY_IF) && !kill && !flush) begin
      if_rvalid = 1'b1;
      if_rdata  = mem_rdata;
    end
    if (resp && (state == ST_BUSY_DM)) begin
      dm_rvalid = 1'b1;
      dm_rdata  = store_q ? 32'h0 : mem_rdata;
    end

    stall_f = reset && if_req && !if_rvalid;
    stall_m = reset && dm_req && !dm_rvalid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a bench-owned memory feeds the DUT,
// a reference memory plus grant/kill rules predict every grant and response.
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_f, stall_m;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int forced_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0] ^ 16'hC3A5, ~w[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Physical memory driven only by the DUT's mem_* port.
  logic [31:0] phys [logic [29:0]];
  logic [31:0] rd_pipe [LAT];
  logic        acc_en = 1'b0, acc_we = 1'b0;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;

  function automatic logic [31:0] phys_rd(input logic [29:0] w);
    return phys.exists(w) ? phys[w] : init_word(w);
  endfunction

  assign mem_rdata = rd_pipe[LAT-1];

  always @(negedge clk) begin
    acc_en    = mem_en;
    acc_we    = mem_we;
    acc_addr  = mem_addr;
    acc_wdata = mem_wdata;
    acc_be    = mem_be;
  end

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = (acc_en && !acc_we) ? phys_rd(acc_addr[31:2]) : 32'hBAD0_0000;
    if (acc_en && acc_we) phys[acc_addr[31:2]] = merge(phys_rd(acc_addr[31:2]), acc_wdata, acc_be);
    acc_en = 1'b0;
  end

  // Reference model: its own memory, updated from the bench's requests in grant order.
  logic [31:0] refm [logic [29:0]];

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return refm.exists(w) ? refm[w] : init_word(w);
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          killed;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];
  bit   busy = 1'b0;
  int   resp_cyc = 0;
  int   starve = 0;

  // Grant observer: predicts the winner of every slot and pushes the expected response.
  always @(negedge clk) begin
    bit slot, exp_dm, exp_if;
    exp_t e;
    if (!reset) begin
      chk("reset_outputs",
          32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall_f, stall_m, mem_be}),
          32'h0);
      chk("reset_buses", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
      fq.delete();
      dq.delete();
      busy   = 1'b0;
      starve = 0;
    end else begin
      slot = !busy || (cyc == resp_cyc);
      if (slot) busy = 1'b0;
      exp_dm = slot && dm_req && !(if_req && starve == SMAX);
      exp_if = slot && if_req && !exp_dm;
      chk("dm_gnt", 32'(dm_gnt), 32'(exp_dm));
      chk("if_gnt", 32'(if_gnt), 32'(exp_if));
      chk("mem_en", 32'(mem_en), 32'(exp_dm || exp_if));
      if (exp_dm) begin
        chk("dm_mem_addr", mem_addr, {dm_addr[31:2], 2'b00});
        chk("dm_mem_we", 32'(mem_we), 32'(dm_we));
        chk("dm_mem_be", 32'(mem_be), dm_we ? 32'(dm_be) : 32'hF);
        e.due    = cyc + LAT;
        e.killed = 1'b0;
        if (dm_we) begin
          chk("dm_mem_wdata", mem_wdata, dm_wdata);
          refm[dm_addr[31:2]] = merge(ref_rd(dm_addr[31:2]), dm_wdata, dm_be);
          e.data = 32'h0;
        end else begin
          e.data = ref_rd(dm_addr[31:2]);
        end
        dq.push_back(e);
        busy = 1'b1;
        resp_cyc = cyc + LAT;
      end
      if (exp_if) begin
        chk("if_mem_addr", mem_addr, {if_addr[31:2], 2'b00});
        chk("if_mem_rd", 32'({mem_we, mem_be}), 32'h0F);
        if (dm_req) forced_cnt++;
        e.due    = cyc + LAT;
        e.data   = ref_rd(if_addr[31:2]);
        e.killed = flush;
        fq.push_back(e);
        busy = 1'b1;
        resp_cyc = cyc + LAT;
      end
      if (flush)
        foreach (fq[i]) if (fq[i].due >= cyc) fq[i].killed = 1'b1;
      if (!if_req || exp_if) starve = 0;
      else if (exp_dm && starve < SMAX) starve++;
    end
  end

  // Response monitor: pops the scoreboard on each due cycle and checks rvalid/rdata/stalls.
  always @(negedge clk) begin
    bit          ev_if, ev_dm;
    logic [31:0] ed_if, ed_dm;
    #1;
    if (reset) begin
      ev_if = 1'b0; ed_if = 32'h0;
      ev_dm = 1'b0; ed_dm = 32'h0;
      if (fq.size() > 0 && fq[0].due == cyc) begin
        ev_if = !fq[0].killed;
        ed_if = ev_if ? fq[0].data : 32'h0;
        void'(fq.pop_front());
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        ev_dm = 1'b1;
        ed_dm = dq[0].data;
        void'(dq.pop_front());
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(ev_if));
      chk("if_rdata", if_rdata, ed_if);
      chk("dm_rvalid", 32'(dm_rvalid), 32'(ev_dm));
      chk("dm_rdata", dm_rdata, ed_dm);
      chk("stall_f", 32'(stall_f), 32'(if_req && !ev_if));
      chk("stall_m", 32'(stall_m), 32'(dm_req && !ev_dm));
    end
  end

  task automatic drain();
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; flush = 1'b0;
    for (int k = 0; k < 40 && (fq.size() + dq.size()) > 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(fq.size() + dq.size()), 32'h0);
  endtask

  task automatic rand_phase(input int ncyc, input int dm_rate);
    bit gi, gd;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      gi = if_gnt;
      gd = dm_gnt;
      @(posedge clk); #1;
      if (!if_req || gi) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!dm_req || gd) begin
        dm_req   = ($urandom_range(0, 9) < dm_rate);
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = {22'h0, 10'($urandom_range(0, 1023))};
        dm_wdata = $urandom;
        dm_be    = 4'($urandom_range(1, 15));
      end
      flush = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; flush = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h100; dm_wdata = 32'h0; dm_be = 4'h0;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'h0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    reset = 1'b1;

    rand_phase(300, 5);
    rand_phase(200, 10);
    drain();
    chk("forced_fetch_seen", 32'(forced_cnt > 0), 32'h1);

    // Reset while a load is in flight: the access is abandoned and never answered.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = dm_gnt;
    end
    chk("rst_load_gnt", 32'(got), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    if_req = 1'b0; dm_addr = 32'h104; reset = 1'b1;
    @(negedge clk);
    chk("post_reset_gnt", 32'(dm_gnt), 32'h1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
